// File: rtl/axis_bram_writer_pkg.sv
// Shared constants for the stream-to-BRAM capture block.
// Byte-lane sizing used to derive write-enable width from the BRAM word width.
package axis_bram_writer_pkg;

    localparam int BYTE_W = 8;

    function automatic int we_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/axis_bram_writer_if.sv
// Bundle of the capture block's stream, done-event, config/status and BRAM signals.
// slave = the capture block's view, master = the driver/observer side.
interface axis_bram_writer_if
    import axis_bram_writer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
);
    logic [BRAM_ADDR_WIDTH-1:0]        cfg_data;
    logic                              trg_flag;
    logic [BRAM_ADDR_WIDTH-1:0]        sts_data;
    logic [AXIS_TDATA_WIDTH-1:0]       s_axis_tdata;
    logic                              s_axis_tvalid;
    logic                              s_axis_tlast;
    logic                              s_axis_tready;
    logic                              m_axis_done_tvalid;
    logic                              m_axis_done_tready;
    logic                              bram_porta_clk;
    logic                              bram_porta_rst;
    logic [BRAM_ADDR_WIDTH-1:0]        bram_porta_addr;
    logic [BRAM_DATA_WIDTH-1:0]        bram_porta_wrdata;
    logic [BRAM_DATA_WIDTH/BYTE_W-1:0] bram_porta_we;

    modport slave (
        input  cfg_data, trg_flag, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
               m_axis_done_tready,
        output sts_data, s_axis_tready, m_axis_done_tvalid,
               bram_porta_clk, bram_porta_rst, bram_porta_addr,
               bram_porta_wrdata, bram_porta_we
    );

    modport master (
        output cfg_data, trg_flag, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
               m_axis_done_tready,
        input  sts_data, s_axis_tready, m_axis_done_tvalid,
               bram_porta_clk, bram_porta_rst, bram_porta_addr,
               bram_porta_wrdata, bram_porta_we
    );

endinterface

// File: rtl/axis_bram_writer.sv
// Captures an AXI-stream frame into BRAM, one word per accepted beat (write in the same cycle, 0 latency).
// Backpressure: tready only while filling; the done event holds until acknowledged, no trigger queueing.
module axis_bram_writer
    import axis_bram_writer_pkg::*;
#(
    parameter int    AXIS_TDATA_WIDTH = 32,
    parameter int    BRAM_DATA_WIDTH  = 32,
    parameter int    BRAM_ADDR_WIDTH  = 10,
    parameter string CONTINUOUS       = "FALSE"
)(
    input  logic                              aclk,
    input  logic                              aresetn,

    input  logic [BRAM_ADDR_WIDTH-1:0]        cfg_data,
    input  logic                              trg_flag,
    output logic [BRAM_ADDR_WIDTH-1:0]        sts_data,

    input  logic [AXIS_TDATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic                              m_axis_done_tvalid,
    input  logic                              m_axis_done_tready,

    output logic                              bram_porta_clk,
    output logic                              bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]        bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]        bram_porta_wrdata,
    output logic [BRAM_DATA_WIDTH/BYTE_W-1:0] bram_porta_we
);

    localparam int WE_W      = BRAM_DATA_WIDTH / BYTE_W;
    localparam bit CONT_MODE = (CONTINUOUS == "TRUE");

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q,  addr_d;

    logic beat;
    logic term;

    assign beat = (state_q == FILL) && s_axis_tvalid;
    // >= rather than == so a cfg_data lowered below addr mid-frame still ends the frame
    assign term = s_axis_tlast || (addr_q >= cfg_data);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (trg_flag) begin
                    state_d = FILL;
                    addr_d  = '0;
                end
            end
            FILL: begin
                if (beat) begin
                    if (!term) begin
                        addr_d = addr_q + 1'b1;
                    end else if (CONT_MODE) begin
                        addr_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (m_axis_done_tready) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign s_axis_tready      = (state_q == FILL);
    assign m_axis_done_tvalid = !CONT_MODE && (state_q == DONE);
    assign sts_data           = addr_q;

    assign bram_porta_clk     = aclk;
    assign bram_porta_rst     = ~aresetn;
    assign bram_porta_addr    = addr_q;
    assign bram_porta_wrdata  = s_axis_tdata[BRAM_DATA_WIDTH-1:0];
    assign bram_porta_we      = {WE_W{beat}};

endmodule

// File: tb/tb_axis_bram_writer.sv
// Directed bench for axis_bram_writer: one-shot instance (i0/d0) and continuous instance (i1/d1).
module tb_axis_bram_writer;

    logic aclk;
    logic aresetn;

    int n_chk;
    int n_fail;

    axis_bram_writer_if #(.AXIS_TDATA_WIDTH(32), .BRAM_DATA_WIDTH(32), .BRAM_ADDR_WIDTH(10)) i0 ();
    axis_bram_writer_if #(.AXIS_TDATA_WIDTH(32), .BRAM_DATA_WIDTH(32), .BRAM_ADDR_WIDTH(10)) i1 ();

    axis_bram_writer #(.CONTINUOUS("FALSE")) d0 (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cfg_data           (i0.cfg_data),
        .trg_flag           (i0.trg_flag),
        .sts_data           (i0.sts_data),
        .s_axis_tdata       (i0.s_axis_tdata),
        .s_axis_tvalid      (i0.s_axis_tvalid),
        .s_axis_tlast       (i0.s_axis_tlast),
        .s_axis_tready      (i0.s_axis_tready),
        .m_axis_done_tvalid (i0.m_axis_done_tvalid),
        .m_axis_done_tready (i0.m_axis_done_tready),
        .bram_porta_clk     (i0.bram_porta_clk),
        .bram_porta_rst     (i0.bram_porta_rst),
        .bram_porta_addr    (i0.bram_porta_addr),
        .bram_porta_wrdata  (i0.bram_porta_wrdata),
        .bram_porta_we      (i0.bram_porta_we)
    );

    axis_bram_writer #(.CONTINUOUS("TRUE")) d1 (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cfg_data           (i1.cfg_data),
        .trg_flag           (i1.trg_flag),
        .sts_data           (i1.sts_data),
        .s_axis_tdata       (i1.s_axis_tdata),
        .s_axis_tvalid      (i1.s_axis_tvalid),
        .s_axis_tlast       (i1.s_axis_tlast),
        .s_axis_tready      (i1.s_axis_tready),
        .m_axis_done_tvalid (i1.m_axis_done_tvalid),
        .m_axis_done_tready (i1.m_axis_done_tready),
        .bram_porta_clk     (i1.bram_porta_clk),
        .bram_porta_rst     (i1.bram_porta_rst),
        .bram_porta_addr    (i1.bram_porta_addr),
        .bram_porta_wrdata  (i1.bram_porta_wrdata),
        .bram_porta_we      (i1.bram_porta_we)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        trg;
        logic        vld;
        logic        last;
        logic        drdy;
        logic [9:0]  cfg;
        logic [31:0] dat;
        logic        e_rdy;
        logic        e_we;
        logic        e_dvld;
        logic [9:0]  e_addr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic trg, input logic vld, input logic last,
                                input logic drdy, input int cfg, input int dat,
                                input logic erdy, input logic ewe, input logic edvld,
                                input int eaddr);
        vec_t r;
        r.trg    = trg;
        r.vld    = vld;
        r.last   = last;
        r.drdy   = drdy;
        r.cfg    = cfg[9:0];
        r.dat    = dat;
        r.e_rdy  = erdy;
        r.e_we   = ewe;
        r.e_dvld = edvld;
        r.e_addr = eaddr[9:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive0(input logic trg, input logic vld, input logic last,
                          input logic drdy, input logic [9:0] cfg, input logic [31:0] dat);
        i0.trg_flag           = trg;
        i0.s_axis_tvalid      = vld;
        i0.s_axis_tlast       = last;
        i0.m_axis_done_tready = drdy;
        i0.cfg_data           = cfg;
        i0.s_axis_tdata       = dat;
    endtask

    initial begin
        int nwr;
        n_chk   = 0;
        n_fail  = 0;
        aresetn = 1'b0;
        drive0(0, 0, 0, 0, 10'd0, 32'd0);
        i1.trg_flag = 0; i1.s_axis_tvalid = 0; i1.s_axis_tlast = 0;
        i1.m_axis_done_tready = 0; i1.cfg_data = 10'd0; i1.s_axis_tdata = 32'd0;

        // reset state
        @(negedge aclk); #1;
        chk("rst tready", {31'd0, i0.s_axis_tready}, 32'd0);
        chk("rst done_tvalid", {31'd0, i0.m_axis_done_tvalid}, 32'd0);
        chk("rst we", {28'd0, i0.bram_porta_we}, 32'd0);
        chk("rst sts", {22'd0, i0.sts_data}, 32'd0);
        chk("rst bram_rst", {31'd0, i0.bram_porta_rst}, 32'd1);
        @(negedge aclk);
        aresetn = 1'b1;

        // cfg=7, 8 beats, done held until tready; trigger in DONE not queued
        vq.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) vq.push_back(mk(0, 1, 0, 0, 7, 32'hA000 + i, 1, 1, 0, i));
        vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, 1, 7));
        vq.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, 1, 7));
        vq.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, 1, 7));
        vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, 0, 0));
        // cfg=15, tlast on 4th beat, trigger in FILL ignored
        vq.push_back(mk(1, 0, 0, 0, 15, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) vq.push_back(mk(i == 1, 1, i == 3, 0, 15, 32'hB000 + i, 1, 1, 0, i));
        vq.push_back(mk(0, 1, 0, 0, 15, 0, 0, 0, 1, 3));
        vq.push_back(mk(0, 0, 0, 1, 15, 0, 0, 0, 1, 3));
        // cfg lowered 10 -> 1 at addr 5
        vq.push_back(mk(1, 0, 0, 0, 10, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vq.push_back(mk(0, 1, 0, 0, 10, 32'hC000 + i, 1, 1, 0, i));
        vq.push_back(mk(0, 0, 0, 0, 10, 0, 1, 0, 0, 5));
        vq.push_back(mk(0, 1, 0, 0, 1, 32'hC005, 1, 1, 0, 5));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 5));
        vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 5));
        // cfg=0: single-word frame
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hD000, 1, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vq[i]) begin
            @(negedge aclk);
            drive0(vq[i].trg, vq[i].vld, vq[i].last, vq[i].drdy, vq[i].cfg, vq[i].dat);
            #1;
            chk($sformatf("v%0d tready", i), {31'd0, i0.s_axis_tready}, {31'd0, vq[i].e_rdy});
            chk($sformatf("v%0d we", i), {28'd0, i0.bram_porta_we}, vq[i].e_we ? 32'hF : 32'h0);
            chk($sformatf("v%0d done_tvalid", i), {31'd0, i0.m_axis_done_tvalid}, {31'd0, vq[i].e_dvld});
            chk($sformatf("v%0d sts", i), {22'd0, i0.sts_data}, {22'd0, vq[i].e_addr});
            if (vq[i].e_we) begin
                chk($sformatf("v%0d addr", i), {22'd0, i0.bram_porta_addr}, {22'd0, vq[i].e_addr});
                chk($sformatf("v%0d wrdata", i), i0.bram_porta_wrdata, vq[i].dat);
            end
        end

        // random tvalid, cfg=3: exactly 4 in-order writes
        @(negedge aclk);
        drive0(1, 0, 0, 0, 10'd3, 32'd0);
        @(negedge aclk);
        i0.trg_flag = 0;
        nwr = 0;
        for (int c = 0; c < 200 && nwr < 4; c++) begin
            if (c > 0) @(negedge aclk);
            i0.s_axis_tvalid = 1'($urandom_range(0, 1));
            i0.s_axis_tdata  = 32'hF000 + nwr;
            #1;
            chk("rnd we", {28'd0, i0.bram_porta_we}, i0.s_axis_tvalid ? 32'hF : 32'h0);
            if (i0.bram_porta_we != 4'h0) begin
                chk("rnd addr", {22'd0, i0.bram_porta_addr}, nwr);
                chk("rnd wrdata", i0.bram_porta_wrdata, 32'hF000 + nwr);
                nwr++;
            end
        end
        chk("rnd write count", nwr, 4);
        @(negedge aclk);
        i0.s_axis_tvalid = 1;
        #1;
        chk("rnd no extra write", {28'd0, i0.bram_porta_we}, 32'd0);
        chk("rnd done_tvalid", {31'd0, i0.m_axis_done_tvalid}, 32'd1);
        chk("rnd sts", {22'd0, i0.sts_data}, 32'd3);
        @(negedge aclk);
        drive0(0, 0, 0, 1, 10'd3, 32'd0);
        @(negedge aclk);
        i0.m_axis_done_tready = 0;

        // continuous mode, cfg=2, 7 beats wrap 0,1,2,0,1,2,0
        i1.trg_flag = 1; i1.cfg_data = 10'd2;
        @(negedge aclk);
        i1.trg_flag = 0;
        for (int k = 0; k < 7; k++) begin
            i1.s_axis_tvalid = 1;
            i1.s_axis_tdata  = 32'hE000 + k;
            #1;
            chk($sformatf("cont%0d we", k), {28'd0, i1.bram_porta_we}, 32'hF);
            chk($sformatf("cont%0d addr", k), {22'd0, i1.bram_porta_addr}, k % 3);
            chk($sformatf("cont%0d wrdata", k), i1.bram_porta_wrdata, 32'hE000 + k);
            chk($sformatf("cont%0d done_tvalid", k), {31'd0, i1.m_axis_done_tvalid}, 32'd0);
            @(negedge aclk);
        end
        i1.s_axis_tvalid = 0;
        #1;
        chk("cont tready after", {31'd0, i1.s_axis_tready}, 32'd1);
        chk("cont done_tvalid after", {31'd0, i1.m_axis_done_tvalid}, 32'd0);
        chk("cont sts after", {22'd0, i1.sts_data}, 32'd1);

        // reset after 3 of 8 beats
        @(negedge aclk);
        drive0(1, 0, 0, 0, 10'd7, 32'd0);
        @(negedge aclk);
        i0.trg_flag = 0;
        for (int k = 0; k < 3; k++) begin
            i0.s_axis_tvalid = 1;
            i0.s_axis_tdata  = 32'h5000 + k;
            #1;
            chk($sformatf("mrst beat%0d addr", k), {22'd0, i0.bram_porta_addr}, k);
            @(negedge aclk);
        end
        #2;
        aresetn = 1'b0;
        #1;
        chk("mrst async tready", {31'd0, i0.s_axis_tready}, 32'd0);
        chk("mrst async we", {28'd0, i0.bram_porta_we}, 32'd0);
        chk("mrst async sts", {22'd0, i0.sts_data}, 32'd0);
        chk("mrst async done_tvalid", {31'd0, i0.m_axis_done_tvalid}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        i0.s_axis_tvalid = 0;
        i0.m_axis_done_tready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk); #1;
            chk("mrst no done", {31'd0, i0.m_axis_done_tvalid}, 32'd0);
            chk("mrst idle tready", {31'd0, i0.s_axis_tready}, 32'd0);
        end
        @(negedge aclk);
        i0.trg_flag = 1;
        @(negedge aclk);
        i0.trg_flag = 0;
        i0.s_axis_tvalid = 1;
        i0.s_axis_tdata  = 32'h6000;
        #1;
        chk("mrst restart we", {28'd0, i0.bram_porta_we}, 32'hF);
        chk("mrst restart addr", {22'd0, i0.bram_porta_addr}, 32'd0);
        @(negedge aclk);
        i0.s_axis_tvalid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
